apb_slave_regfile: RTL and testbench

APB completer that terminates transfers issued by the team's APB master on the Pselx/Penable/Pwrite/Paddr/Pwdata bus and returns Prdata/Pready/Pslverr. It holds eight 16-bit registers:
- six read/write registers;
- one read-only counter of completed transfers;
- one read-only ID register.

Pready wait states are programmable at elaboration. It sits directly on the master's bus as the only selected slave.

---
 rtl/apb_pkg.sv | 11 +
 rtl/apb_regfile.sv | 30 +++
 rtl/apb_slave_regfile.sv | 51 +++++
 tb/tb_apb_slave_regfile.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: bus widths, FSM state encoding and register map shared by APB master and slave
package apb_pkg;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;
  localparam logic [ADDR_W-1:0] ADDR_XFER_CNT = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_ID = 3'd7;
  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;
  function automatic logic is_ro(input logic [ADDR_W-1:0] a);
    return a >= ADDR_XFER_CNT;
  endfunction
endpackage

// File: rtl/apb_regfile.sv
// apb_regfile: six R/W registers, completed-transfer counter and read mux
module apb_regfile
  import apb_pkg::*;
#(
  parameter logic [DATA_W-1:0] ID_VALUE = 16'hA5B0
) (
  input  logic              Pclk,
  input  logic              Prst,
  input  logic              we,
  input  logic              inc,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] regs [6];
  logic [DATA_W-1:0] xfer_cnt;
  always_ff @(posedge Pclk or posedge Prst)
    if (Prst) begin
      for (int i = 0; i < 6; i++) regs[i] <= '0;
      xfer_cnt <= '0;
    end else begin
      for (int i = 0; i < 6; i++) if (we && addr == 3'(i)) regs[i] <= wdata;
      if (inc) xfer_cnt <= xfer_cnt + 1'b1;
    end
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 6; i++) if (addr == 3'(i)) rdata = regs[i];
    rdata = addr == ADDR_ID ? ID_VALUE : addr == ADDR_XFER_CNT ? xfer_cnt : rdata;
  end
endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer with programmable wait states over an 8-entry register file
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int                WAIT_CYCLES = 1,
  parameter logic [DATA_W-1:0] ID_VALUE    = 16'hA5B0
) (
  input  logic              Pclk,
  input  logic              Prst,
  input  logic              Pselx,
  input  logic              Penable,
  input  logic              Pwrite,
  input  logic [ADDR_W-1:0] Paddr,
  input  logic [DATA_W-1:0] Pwdata,
  output logic [DATA_W-1:0] Prdata,
  output logic              Pready,
  output logic              Pslverr
);
  localparam logic [3:0] WMAX = 4'(WAIT_CYCLES);
  state_t            state;
  logic [3:0]        wcnt;
  logic              rdy;
  logic              done;
  logic [DATA_W-1:0] rdata;
  // Pready comes only from registered state so it never loops back through the master
  assign rdy  = state == ACCESS && wcnt == WMAX;
  assign done = rdy && Pselx && Penable;
  always_ff @(posedge Pclk or posedge Prst)
    if (Prst) begin
      state <= IDLE;
      wcnt  <= '0;
    end else if (state == IDLE) begin
      if (Pselx && !Penable) begin
        state <= ACCESS;
        wcnt  <= '0;
      end
    end else if (!Pselx || done) state <= IDLE;
    else if (wcnt != WMAX) wcnt <= wcnt + 1'b1;
  apb_regfile #(.ID_VALUE(ID_VALUE)) u_rf (
    .Pclk (Pclk),
    .Prst (Prst),
    .we   (done && Pwrite && !is_ro(Paddr)),
    .inc  (done),
    .addr (Paddr),
    .wdata(Pwdata),
    .rdata(rdata)
  );
  assign Pready  = rdy;
  assign Pslverr = rdy && Pwrite && is_ro(Paddr);
  assign Prdata  = (rdy && !Pwrite) ? rdata : '0;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: directed checks on three instances with WAIT_CYCLES 1, 0 and 3
module tb_apb_slave_regfile;
  logic        Pclk = 1'b0;
  logic        Prst = 1'b1;
  logic [2:0]  sel = '0;
  logic        Penable = 1'b0;
  logic        Pwrite = 1'b0;
  logic [2:0]  Paddr = '0;
  logic [15:0] Pwdata = '0;
  logic [15:0] rd [3];
  logic        rdy [3];
  logic        err [3];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] ro;
  logic        eo;
  int          acc;
  time         t0;
  always #5 Pclk = ~Pclk;
  apb_slave_regfile #(.WAIT_CYCLES(1), .ID_VALUE(16'hA5B0)) u_w1 (
    .Pclk(Pclk), .Prst(Prst), .Pselx(sel[0]), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(rd[0]), .Pready(rdy[0]), .Pslverr(err[0]));
  apb_slave_regfile #(.WAIT_CYCLES(0), .ID_VALUE(16'hA5B0)) u_w0 (
    .Pclk(Pclk), .Prst(Prst), .Pselx(sel[1]), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(rd[1]), .Pready(rdy[1]), .Pslverr(err[1]));
  apb_slave_regfile #(.WAIT_CYCLES(3), .ID_VALUE(16'hA5B0)) u_w3 (
    .Pclk(Pclk), .Prst(Prst), .Pselx(sel[2]), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(rd[2]), .Pready(rdy[2]), .Pslverr(err[2]));

  // Starts at #1 after an edge and returns at #1 after the completion edge.
  task automatic xfer(input int d, input logic w, input logic [2:0] a, input logic [15:0] wd,
                      output logic [15:0] r, output logic e, output int n);
    sel[d] = 1'b1; Penable = 1'b0; Pwrite = w; Paddr = a; Pwdata = wd;
    @(posedge Pclk); #1;
    Penable = 1'b1; n = 1;
    while (!rdy[d] && n < 20) begin @(posedge Pclk); #1; n++; end
    r = rd[d]; e = err[d];
    checks++; if (rdy[d] !== 1'b1) begin errors++; $display("FAIL timeout dut=%0d got Pready=%b want 1", d, rdy[d]); end
    @(posedge Pclk); #1;
    sel[d] = 1'b0; Penable = 1'b0;
  endtask

  task automatic do_reset();
    Prst = 1'b1; sel = '0; Penable = 1'b0;
    repeat (2) @(posedge Pclk); #1;
    Prst = 1'b0;
    @(posedge Pclk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge Pclk); #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({rdy[i], err[i], rd[i]} !== 18'h0) begin errors++; $display("FAIL reset_out dut=%0d got rdy=%b err=%b rd=%h want 0", i, rdy[i], err[i], rd[i]); end
    end
    Prst = 1'b0;
    @(posedge Pclk); #1;
    xfer(1, 1'b1, 3'd3, 16'h5555, ro, eo, acc);
    sel[1] = 1'b1; Penable = 1'b0; Pwrite = 1'b0; Paddr = 3'd3;
    @(posedge Pclk); #1;
    Penable = 1'b1; #1;
    checks++; if (rd[1] !== 16'h5555) begin errors++; $display("FAIL pre_reset_rd got %h want 5555", rd[1]); end
    Prst = 1'b1; #1;
    checks++; if (rdy[1] !== 1'b0) begin errors++; $display("FAIL mid_reset_rdy got %b want 0", rdy[1]); end
    checks++; if (rd[1] !== 16'h0000) begin errors++; $display("FAIL mid_reset_rd got %h want 0000", rd[1]); end
    sel[1] = 1'b0; Penable = 1'b0;
    @(posedge Pclk); #1;
    Prst = 1'b0;
    @(posedge Pclk); #1;
    xfer(1, 1'b0, 3'd3, 16'h0, ro, eo, acc);
    checks++; if (ro !== 16'h0000) begin errors++; $display("FAIL reset_reg3 got %h want 0000", ro); end
    xfer(1, 1'b0, 3'd6, 16'h0, ro, eo, acc);
    checks++; if (ro !== 16'h0001) begin errors++; $display("FAIL reset_cnt got %h want 0001", ro); end
  endtask

  task automatic test_wait1();
    do_reset();
    xfer(0, 1'b1, 3'd2, 16'h1234, ro, eo, acc);
    checks++; if (acc !== 2) begin errors++; $display("FAIL w1_ready_cycle got %0d want 2", acc); end
    checks++; if (eo !== 1'b0) begin errors++; $display("FAIL w1_wr_err got %b want 0", eo); end
    checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL w1_ready_after got %b want 0", rdy[0]); end
    xfer(0, 1'b0, 3'd6, 16'h0, ro, eo, acc);
    checks++; if (ro !== 16'h0001) begin errors++; $display("FAIL w1_cnt got %h want 0001", ro); end
    xfer(0, 1'b0, 3'd2, 16'h0, ro, eo, acc);
    checks++; if (ro !== 16'h1234) begin errors++; $display("FAIL w1_rd got %h want 1234", ro); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    t0 = $time;
    xfer(1, 1'b1, 3'd0, 16'hBEEF, ro, eo, acc);
    checks++; if (acc !== 1) begin errors++; $display("FAIL b2b_wr_len got %0d want 1", acc); end
    xfer(1, 1'b0, 3'd0, 16'h0, ro, eo, acc);
    checks++; if (ro !== 16'hBEEF) begin errors++; $display("FAIL b2b_rd got %h want beef", ro); end
    checks++; if (eo !== 1'b0) begin errors++; $display("FAIL b2b_err got %b want 0", eo); end
    checks++; if ($time - t0 !== 40) begin errors++; $display("FAIL b2b_time got %0t want 40", $time - t0); end
  endtask

  task automatic test_slverr();
    do_reset();
    xfer(1, 1'b1, 3'd7, 16'hFFFF, ro, eo, acc);
    checks++; if (eo !== 1'b1) begin errors++; $display("FAIL id_wr_err got %b want 1", eo); end
    xfer(1, 1'b0, 3'd7, 16'h0, ro, eo, acc);
    checks++; if (ro !== 16'hA5B0) begin errors++; $display("FAIL id_rd got %h want a5b0", ro); end
    checks++; if (eo !== 1'b0) begin errors++; $display("FAIL id_rd_err got %b want 0", eo); end
    xfer(1, 1'b1, 3'd6, 16'hFFFF, ro, eo, acc);
    checks++; if (eo !== 1'b1) begin errors++; $display("FAIL cnt_wr_err got %b want 1", eo); end
    xfer(1, 1'b0, 3'd6, 16'h0, ro, eo, acc);
    checks++; if (ro !== 16'h0003) begin errors++; $display("FAIL cnt_after_err got %h want 0003", ro); end
  endtask

  task automatic test_abort();
    do_reset();
    sel[2] = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = 3'd4; Pwdata = 16'h7777;
    @(posedge Pclk); #1;
    sel[2] = 1'b0;
    checks++; if (rdy[2] !== 1'b0) begin errors++; $display("FAIL abort_rdy got %b want 0", rdy[2]); end
    @(posedge Pclk); #1;
    xfer(2, 1'b0, 3'd4, 16'h0, ro, eo, acc);
    checks++; if (ro !== 16'h0000) begin errors++; $display("FAIL abort_reg4 got %h want 0000", ro); end
    checks++; if (acc !== 4) begin errors++; $display("FAIL w3_ready_cycle got %0d want 4", acc); end
    xfer(2, 1'b0, 3'd6, 16'h0, ro, eo, acc);
    checks++; if (ro !== 16'h0001) begin errors++; $display("FAIL abort_cnt got %h want 0001", ro); end
  endtask

  task automatic test_wrap();
    do_reset();
    force u_w0.u_rf.xfer_cnt = 16'hFFFF;
    #1;
    release u_w0.u_rf.xfer_cnt;
    xfer(1, 1'b0, 3'd6, 16'h0, ro, eo, acc);
    checks++; if (ro !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre got %h want ffff", ro); end
    xfer(1, 1'b0, 3'd6, 16'h0, ro, eo, acc);
    checks++; if (ro !== 16'h0000) begin errors++; $display("FAIL wrap got %h want 0000", ro); end
  endtask

  initial begin
    test_reset();
    test_wait1();
    test_back_to_back();
    test_slverr();
    test_abort();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
